// File: rtl/compress_write_unit_if.sv
// Bundle for the compress write unit: upstream beat handshake, register-file
// write port and sequence status.
interface compress_write_unit_if #(
    parameter int OFFSET_W = 5,
    parameter int DATA_W   = 32
);
    // Both handshakes are valid/ready. A transfer happens on a rising edge
    // where valid and ready are both 1. The producer holds valid and its payload
    // stable until that edge. Ready may depend only on registered state.
    logic                start;
    logic                in_valid;
    logic [1:0]          wen;
    logic [OFFSET_W-1:0] woffset0;
    logic [OFFSET_W-1:0] woffset1;
    logic [DATA_W-1:0]   wdata0;
    logic [DATA_W-1:0]   wdata1;
    logic                last;
    logic                in_ready;
    logic                vrf_wen;
    logic [OFFSET_W-1:0] vrf_woffset;
    logic [DATA_W-1:0]   vrf_wdata;
    logic                vrf_ready;
    logic                busy;
    logic                done;
    logic [OFFSET_W:0]   elem_count;

    modport master (
        output start, in_valid, wen, woffset0, woffset1, wdata0, wdata1, last,
        output vrf_ready,
        input  in_ready, vrf_wen, vrf_woffset, vrf_wdata, busy, done, elem_count
    );

    modport slave (
        input  start, in_valid, wen, woffset0, woffset1, wdata0, wdata1, last,
        input  vrf_ready,
        output in_ready, vrf_wen, vrf_woffset, vrf_wdata, busy, done, elem_count
    );
endinterface

// File: rtl/compress_write_unit.sv
// Compress write unit: packs enabled elements of two-element beats into a small
// FIFO and drains them, one per cycle, into the register-file write port.
module compress_write_unit #(
    parameter int DEPTH    = 4,
    parameter int OFFSET_W = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    compress_write_unit_if.slave  bus,
    output logic [1:0]            dbg_state_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [OFFSET_W:0]   elem_cnt_q, elem_cnt_d;

    logic [OFFSET_W-1:0] off_mem  [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];

    logic                in_ready;
    logic                accept;
    logic                enq0, enq1;
    logic [CNT_W-1:0]    enq_n;
    logic                vrf_wen;
    logic                deq;
    logic [PTR_W-1:0]    wr1_idx;

    // Room for a full two-element beat is required before a beat is taken.
    always_comb begin
        in_ready = (state_q == RUN) && (count_q <= CNT_W'(DEPTH - 2));
        accept   = bus.in_valid && in_ready;
        enq0     = accept && bus.wen[0];
        enq1     = accept && bus.wen[1];
        enq_n    = CNT_W'(enq0) + CNT_W'(enq1);
        vrf_wen  = (count_q != '0);
        deq      = vrf_wen && bus.vrf_ready;
        wr1_idx  = wr_ptr_q + PTR_W'(enq0);
        count_d  = count_q + enq_n - CNT_W'(deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    end

    always_comb begin
        state_d    = state_q;
        elem_cnt_d = elem_cnt_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (accept && bus.last) state_d = DRAIN;
            DRAIN:   if (count_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE && bus.start) begin
            elem_cnt_d = '0;
        end else if (deq) begin
            elem_cnt_d = elem_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            elem_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            elem_cnt_q <= elem_cnt_d;
        end
    end

    // Element 1 lands right after element 0 when both are enabled.
    always_ff @(posedge CLK) begin
        if (enq0) begin
            off_mem[wr_ptr_q]  <= bus.woffset0;
            data_mem[wr_ptr_q] <= bus.wdata0;
        end
        if (enq1) begin
            off_mem[wr1_idx]  <= bus.woffset1;
            data_mem[wr1_idx] <= bus.wdata1;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.vrf_wen     = vrf_wen;
    assign bus.vrf_woffset = off_mem[rd_ptr_q];
    assign bus.vrf_wdata   = data_mem[rd_ptr_q];
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.elem_count  = elem_cnt_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_compress_write_unit.sv
// Bench for compress_write_unit: directed scenarios plus random sequences,
// checked against a queue model of the pending register-file writes.
module tb_compress_write_unit;
    localparam int DEPTH    = 4;
    localparam int OFFSET_W = 5;
    localparam int DATA_W   = 32;
    localparam int ENTRY_W  = OFFSET_W + DATA_W;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] dbg_state;

    compress_write_unit_if #(.OFFSET_W(OFFSET_W), .DATA_W(DATA_W)) bus ();

    compress_write_unit #(.DEPTH(DEPTH), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    logic [ENTRY_W-1:0] exp_q[$];
    int                 wr_cyc_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_elem = 0;
    int dut_wr_cnt = 0;
    logic prev_done = 1'b0;
    int ready_mode = 0;
    logic ready_fix = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // vrf_ready source: fixed, toggling, or random.
    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            1:       bus.vrf_ready = ~bus.vrf_ready;
            2:       bus.vrf_ready = 1'($urandom_range(0, 1));
            default: bus.vrf_ready = ready_fix;
        endcase
    end

    // Monitor: every pending element must appear on the write port in order.
    always @(negedge CLK) begin
        int occ;
        cyc++;
        if (RST) begin
            exp_q.delete();
            prev_done = 1'b0;
        end else begin
            occ = exp_q.size();
            check("vrf_wen", 64'(bus.vrf_wen), 64'(occ != 0));
            if (bus.vrf_wen && bus.vrf_ready) dut_wr_cnt++;
            if (bus.vrf_wen && occ != 0) begin
                check("vrf_entry", 64'({bus.vrf_woffset, bus.vrf_wdata}), 64'(exp_q[0]));
                if (bus.vrf_ready) begin
                    void'(exp_q.pop_front());
                    exp_elem++;
                    wr_cyc_q.push_back(cyc);
                end
            end
            if (bus.in_ready) check("in_ready_room", 64'(occ <= DEPTH - 2), 64'd1);
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc = cyc;
                if (bus.wen[0]) exp_q.push_back({bus.woffset0, bus.wdata0});
                if (bus.wen[1]) exp_q.push_back({bus.woffset1, bus.wdata1});
            end
            if (bus.done) check("done_single", 64'(prev_done), 64'd0);
            prev_done = bus.done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_seq();
        bus.start = 1'b1;
        exp_elem  = 0;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] wen, input logic [OFFSET_W-1:0] o0,
                             input logic [OFFSET_W-1:0] o1, input logic [DATA_W-1:0] d0,
                             input logic [DATA_W-1:0] d1, input logic lst);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.wen      = wen;
        bus.woffset0 = o0;
        bus.woffset1 = o1;
        bus.wdata0   = d0;
        bus.wdata1   = d1;
        bus.last     = lst;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("beat_timeout", 64'd0, 64'd1);
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        bus.wen      = 2'b00;
        bus.last     = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        logic found;
        found = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge CLK);
            if (bus.done) begin
                found = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(found), 64'd1);
        check("drained_at_done", 64'(exp_q.size()), 64'd0);
        @(negedge CLK);
        check("done_cleared", 64'(bus.done), 64'd0);
        check("idle_after_done", 64'(bus.busy), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_elem(input string tag);
        @(negedge CLK);
        check(tag, 64'(bus.elem_count), 64'(exp_elem));
        @(posedge CLK);
        #1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int snap;
        int nb;
        logic [1:0] w;
        bus.start = 0; bus.in_valid = 0; bus.wen = 0; bus.woffset0 = 0; bus.woffset1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0; bus.last = 0; bus.vrf_ready = 0;

        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_vrf_wen", 64'(bus.vrf_wen), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_elem_count", 64'(bus.elem_count), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(posedge CLK); #1; RST = 1'b0;
        step(2);

        // Single two-element beat, consumer always ready.
        ready_fix = 1'b1; step(2);
        wr_cyc_q.delete();
        start_seq();
        send_beat(2'b11, 5'd0, 5'd1, 32'hAAAA_0001, 32'hBBBB_0002, 1'b1);
        wait_done(50);
        check("basic_writes", 64'(wr_cyc_q.size()), 64'd2);
        if (wr_cyc_q.size() == 2) begin
            check("basic_first_latency", 64'(wr_cyc_q[0] - acc_cyc), 64'd1);
            check("basic_back_to_back", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd1);
        end
        check_elem("basic_elem_count");

        // Back-pressure: FIFO fills after DEPTH/2 full beats.
        ready_fix = 1'b0; step(2);
        start_seq();
        for (int i = 0; i < DEPTH / 2; i++)
            send_beat(2'b11, 5'(2 * i), 5'(2 * i + 1), $urandom, $urandom, 1'b0);
        @(negedge CLK);
        check("in_ready_full", 64'(bus.in_ready), 64'd0);
        step(3);
        check("in_ready_still_full", 64'(bus.in_ready), 64'd0);
        ready_fix = 1'b1;
        send_beat(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        wait_done(60);
        check_elem("bp_elem_count");

        // Element 1 only, then an empty last beat.
        snap = dut_wr_cnt;
        start_seq();
        send_beat(2'b10, 5'd3, 5'd7, 32'h1111_1111, 32'hCCCC_0003, 1'b0);
        send_beat(2'b00, 5'd9, 5'd9, 32'h2222_2222, 32'h3333_3333, 1'b1);
        wait_done(50);
        check("wen10_writes", 64'(dut_wr_cnt - snap), 64'd1);
        check_elem("wen10_elem_count");

        // Start during RUN and DRAIN is ignored.
        start_seq();
        send_beat(2'b01, 5'd3, 5'd0, 32'hD0D0_0001, 32'd0, 1'b0);
        step(3);
        pulse_start();
        @(negedge CLK);
        check("run_start_busy", 64'(bus.busy), 64'd1);
        check("run_start_elem", 64'(bus.elem_count), 64'd1);
        ready_fix = 1'b0; step(2);
        send_beat(2'b11, 5'd4, 5'd5, 32'hD0D0_0002, 32'hD0D0_0003, 1'b1);
        step(1);
        pulse_start();
        @(negedge CLK);
        check("drain_start_busy", 64'(bus.busy), 64'd1);
        check("drain_start_elem", 64'(bus.elem_count), 64'd1);
        step(1);
        ready_fix = 1'b1;
        wait_done(50);
        check_elem("start_ignored_elem_count");

        // Reset with three buffered entries.
        ready_fix = 1'b0; step(2);
        start_seq();
        send_beat(2'b11, 5'd10, 5'd11, $urandom, $urandom, 1'b0);
        send_beat(2'b01, 5'd12, 5'd0, $urandom, 32'd0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_vrf_wen", 64'(bus.vrf_wen), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_elem_count", 64'(bus.elem_count), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        exp_elem = 0;
        @(posedge CLK); #1; RST = 1'b0;
        ready_fix = 1'b1;
        snap = dut_wr_cnt;
        bus.in_valid = 1'b1; bus.wen = 2'b11;
        step(6);
        bus.in_valid = 1'b0; bus.wen = 2'b00;
        check("post_rst_no_writes", 64'(dut_wr_cnt - snap), 64'd0);
        check_elem("post_rst_elem_count");

        // Twelve single-element beats, consumer ready toggling.
        ready_mode = 1;
        start_seq();
        for (int i = 0; i < 12; i++) begin
            w = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            send_beat(w, 5'($urandom), 5'($urandom), $urandom, $urandom, 1'(i == 11));
        end
        wait_done(200);
        check_elem("wrap_elem_count");
        check("wrap_elem_is_12", 64'(exp_elem), 64'd12);

        // Random sequences with random consumer stalls and upstream gaps.
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            start_seq();
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                step($urandom_range(0, 2));
                send_beat(2'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
                          1'(b == nb - 1));
            end
            wait_done(200);
            check_elem("rand_elem_count");
        end

        ready_mode = 0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
